// File: rtl/morse_key_decoder_if.sv
// Morse key decoder signal bundle: raw key in, symbol/character results out.
// Latency: none (wires only).
// Backpressure: none; all results are single-cycle pulses the sink must take.
// Ports (as seen by the decoder through the slave modport):
//   key          in   raw push-button, 1 = pressed, asynchronous
//   symbol_valid out  one-cycle pulse, symbol classified
//   symbol       out  0 = DOT, 1 = DASH, valid with symbol_valid
//   char_valid   out  one-cycle pulse, character complete
//   char_len     out  symbols in character (1..5)
//   char_bits    out  symbol k at bit k, unused bits 0
//   char_error   out  more than 5 symbols were keyed
//   ascii        out  decoded character (0 unless MORSE_ASCII_EN)
//   busy         out  decoder not idle
interface morse_key_decoder_if;
   logic       key;
   logic       symbol_valid;
   logic       symbol;
   logic       char_valid;
   logic [2:0] char_len;
   logic [4:0] char_bits;
   logic       char_error;
   logic [7:0] ascii;
   logic       busy;

   // master: key source and result sink (board / text logic side)
   modport master (
      output key,
      input  symbol_valid, symbol, char_valid, char_len, char_bits,
             char_error, ascii, busy
   );

   // slave: the decoder itself
   modport slave (
      input  key,
      output symbol_valid, symbol, char_valid, char_len, char_bits,
             char_error, ascii, busy
   );
endinterface

// File: rtl/morse_key_decoder.sv
// Morse key decoder: synchronise + debounce one raw key, time presses as DOT/DASH, group into characters.
// Latency: raw edge -> debounced edge 2+DEBOUNCE_CYCLES cycles; debounced release -> symbol_valid 1 cycle.
// Backpressure: none; symbol_valid/char_valid are single-cycle pulses with results held that cycle only.
// Ports: clk_i (rising edge), rst_i (async active-high), bus (morse_key_decoder_if.slave).
// Optional feature macro: MORSE_ASCII_EN enables the registered ITU lookup on ascii; otherwise ascii = 0.
module morse_key_decoder #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DASH_CYCLES     = 25000000,
   parameter int GAP_CYCLES      = 50000000,
   parameter int CNT_W           = 26
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   morse_key_decoder_if.slave   bus
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_CYCLES);
   localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_GAP} state_t;

   // ---------------- input synchroniser and debouncer ----------------
   logic             sync1_q, sync2_q;
   logic             db_q, db_d, db_prev_q;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
   logic             arm_q, arm_d;
   logic             rise, fall;

   always_comb begin
      db_d     = db_q;
      db_cnt_d = '0;
      if (sync2_q != db_q) begin
         if (db_cnt_q == DEB_LAST) begin
            db_d = ~db_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   // The synchroniser resets to "pressed" so a key held through reset never
   // looks like a fresh press; presses are only honoured once the key has
   // been seen released (arm_q).
   assign arm_d = arm_q | (~sync2_q & ~db_q);
   assign rise  = db_q & ~db_prev_q & arm_q;
   assign fall  = ~db_q & db_prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         db_cnt_q  <= '0;
         arm_q     <= 1'b0;
      end else begin
         sync1_q   <= bus.key;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         db_cnt_q  <= db_cnt_d;
         arm_q     <= arm_d;
      end
   end

   // ---------------- symbol / character FSM ----------------
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;      // press length in PRESS, gap length in GAP
   logic [2:0]       len_q, len_d;
   logic [4:0]       bits_q, bits_d;
   logic             err_q, err_d;

   logic             sym_vld_q, sym_vld_d;
   logic             sym_q, sym_d;
   logic             chr_vld_q, chr_vld_d;
   logic [2:0]       chr_len_q, chr_len_d;
   logic [4:0]       chr_bits_q, chr_bits_d;
   logic             chr_err_q, chr_err_d;

`ifdef MORSE_ASCII_EN
   logic [7:0]       ascii_q, ascii_d;

   // ITU table keyed on {length, pattern}; pattern bit k is symbol k, DASH = 1.
   function automatic logic [7:0] itu_lookup(input logic [2:0] len, input logic [4:0] bits);
      logic [7:0] r;
      case ({len, bits})
         {3'd2, 5'b00010}: r = 8'h41; // A .-
         {3'd4, 5'b00001}: r = 8'h42; // B -...
         {3'd4, 5'b00101}: r = 8'h43; // C -.-.
         {3'd3, 5'b00001}: r = 8'h44; // D -..
         {3'd1, 5'b00000}: r = 8'h45; // E .
         {3'd4, 5'b00100}: r = 8'h46; // F ..-.
         {3'd3, 5'b00011}: r = 8'h47; // G --.
         {3'd4, 5'b00000}: r = 8'h48; // H ....
         {3'd2, 5'b00000}: r = 8'h49; // I ..
         {3'd4, 5'b01110}: r = 8'h4A; // J .---
         {3'd3, 5'b00101}: r = 8'h4B; // K -.-
         {3'd4, 5'b00010}: r = 8'h4C; // L .-..
         {3'd2, 5'b00011}: r = 8'h4D; // M --
         {3'd2, 5'b00001}: r = 8'h4E; // N -.
         {3'd3, 5'b00111}: r = 8'h4F; // O ---
         {3'd4, 5'b00110}: r = 8'h50; // P .--.
         {3'd4, 5'b01011}: r = 8'h51; // Q --.-
         {3'd3, 5'b00010}: r = 8'h52; // R .-.
         {3'd3, 5'b00000}: r = 8'h53; // S ...
         {3'd1, 5'b00001}: r = 8'h54; // T -
         {3'd3, 5'b00100}: r = 8'h55; // U ..-
         {3'd4, 5'b01000}: r = 8'h56; // V ...-
         {3'd3, 5'b00110}: r = 8'h57; // W .--
         {3'd4, 5'b01001}: r = 8'h58; // X -..-
         {3'd4, 5'b01101}: r = 8'h59; // Y -.--
         {3'd4, 5'b00011}: r = 8'h5A; // Z --..
         {3'd5, 5'b11111}: r = 8'h30; // 0
         {3'd5, 5'b11110}: r = 8'h31; // 1
         {3'd5, 5'b11100}: r = 8'h32; // 2
         {3'd5, 5'b11000}: r = 8'h33; // 3
         {3'd5, 5'b10000}: r = 8'h34; // 4
         {3'd5, 5'b00000}: r = 8'h35; // 5
         {3'd5, 5'b00001}: r = 8'h36; // 6
         {3'd5, 5'b00011}: r = 8'h37; // 7
         {3'd5, 5'b00111}: r = 8'h38; // 8
         {3'd5, 5'b01111}: r = 8'h39; // 9
         default:          r = 8'h3F; // '?'
      endcase
      return r;
   endfunction
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      bits_d     = bits_q;
      err_d      = err_q;
      sym_vld_d  = 1'b0;
      sym_d      = 1'b0;
      chr_vld_d  = 1'b0;
      chr_len_d  = '0;
      chr_bits_d = '0;
      chr_err_d  = 1'b0;
`ifdef MORSE_ASCII_EN
      ascii_d    = '0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_PRESS;
               cnt_d   = CNT_ONE;
            end
         end
         ST_PRESS: begin
            if (fall) begin
               state_d   = ST_GAP;
               cnt_d     = CNT_ONE;
               sym_vld_d = 1'b1;
               sym_d     = (cnt_q >= DASH_C);
               if (len_q < 3'd5) begin
                  bits_d[len_q] = sym_d;
                  len_d         = len_q + 3'd1;
               end else begin
                  err_d = 1'b1;   // sixth+ symbol: reported but not stored
               end
            end else if (cnt_q < DASH_C) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_GAP: begin
            // Timeout is checked first so a press landing on the timeout
            // cycle both closes the character and starts the next one.
            if (cnt_q >= GAP_C) begin
               chr_vld_d  = 1'b1;
               chr_len_d  = len_q;
               chr_bits_d = bits_q;
               chr_err_d  = err_q;
`ifdef MORSE_ASCII_EN
               ascii_d    = err_q ? 8'h3F : itu_lookup(len_q, bits_q);
`endif
               len_d      = '0;
               bits_d     = '0;
               err_d      = 1'b0;
               if (rise) begin
                  state_d = ST_PRESS;
                  cnt_d   = CNT_ONE;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end else if (rise) begin
               state_d = ST_PRESS;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         bits_q     <= '0;
         err_q      <= 1'b0;
         sym_vld_q  <= 1'b0;
         sym_q      <= 1'b0;
         chr_vld_q  <= 1'b0;
         chr_len_q  <= '0;
         chr_bits_q <= '0;
         chr_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         bits_q     <= bits_d;
         err_q      <= err_d;
         sym_vld_q  <= sym_vld_d;
         sym_q      <= sym_d;
         chr_vld_q  <= chr_vld_d;
         chr_len_q  <= chr_len_d;
         chr_bits_q <= chr_bits_d;
         chr_err_q  <= chr_err_d;
      end
   end

`ifdef MORSE_ASCII_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ascii_q <= '0;
      end else begin
         ascii_q <= ascii_d;
      end
   end
   assign bus.ascii = ascii_q;
`else
   assign bus.ascii = 8'h00;
`endif

   assign bus.symbol_valid = sym_vld_q;
   assign bus.symbol       = sym_q;
   assign bus.char_valid   = chr_vld_q;
   assign bus.char_len     = chr_len_q;
   assign bus.char_bits    = chr_bits_q;
   assign bus.char_error   = chr_err_q;
   assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder with DEBOUNCE=4, DASH=20, GAP=40.
// Latency: n/a.
// Backpressure: n/a.
module tb_morse_key_decoder;

   logic clk;
   logic rst;
   int   checks;
   int   passes;

   morse_key_decoder_if bus ();

   morse_key_decoder #(
      .DEBOUNCE_CYCLES (4),
      .DASH_CYCLES     (20),
      .GAP_CYCLES      (40),
      .CNT_W           (26)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // recorded DUT events
   logic       sym_q[$];
   logic [2:0] clen_q[$];
   logic [4:0] cbits_q[$];
   logic       cerr_q[$];
   logic [7:0] casc_q[$];
   logic       busy_seen;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.symbol_valid) sym_q.push_back(bus.symbol);
         if (bus.char_valid) begin
            clen_q.push_back(bus.char_len);
            cbits_q.push_back(bus.char_bits);
            cerr_q.push_back(bus.char_error);
            casc_q.push_back(bus.ascii);
         end
         if (bus.busy) busy_seen = 1'b1;
      end
   end

   function automatic logic [7:0] exp_ascii(input logic [7:0] a);
`ifdef MORSE_ASCII_EN
      return a;
`else
      return 8'h00;
`endif
   endfunction

   task automatic clear_log();
      sym_q.delete();
      clen_q.delete();
      cbits_q.delete();
      cerr_q.delete();
      casc_q.delete();
      busy_seen = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int n);
      bus.key = 1'b1;
      wait_cyc(n);
      bus.key = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.key = 1'b0;
      wait_cyc(3);
      checks++;
      if ({bus.symbol_valid, bus.symbol, bus.char_valid, bus.char_len, bus.char_bits,
           bus.char_error, bus.ascii, bus.busy} !== 20'd0)
         $display("FAIL reset_outputs: got sv=%b s=%b cv=%b len=%0d bits=%b err=%b asc=%h busy=%b, want all 0",
                  bus.symbol_valid, bus.symbol, bus.char_valid, bus.char_len, bus.char_bits,
                  bus.char_error, bus.ascii, bus.busy);
      else passes++;
      rst = 1'b0;
      wait_cyc(10);
      checks++;
      if (bus.busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", bus.busy);
      else passes++;
   endtask

   // single DOT 'E', also checks the debounce latency seen on busy
   task automatic test_single_dot();
      clear_log();
      bus.key = 1'b1;
      wait_cyc(6);
      checks++;
      if (bus.busy !== 1'b0) $display("FAIL debounce_early: busy=%b want 0 after 6 cycles", bus.busy);
      else passes++;
      wait_cyc(1);
      checks++;
      if (bus.busy !== 1'b1) $display("FAIL debounce_latency: busy=%b want 1 after 7 cycles", bus.busy);
      else passes++;
      wait_cyc(3);
      bus.key = 1'b0;
      wait_cyc(60);
      checks++;
      if (sym_q.size() !== 1 || sym_q[0] !== 1'b0)
         $display("FAIL dot_symbol: count=%0d first=%b want count=1 first=0", sym_q.size(), sym_q[0]);
      else passes++;
      checks++;
      if (clen_q.size() !== 1 || {clen_q[0], cbits_q[0], cerr_q[0], casc_q[0]} !== {3'd1, 5'b00000, 1'b0, exp_ascii(8'h45)})
         $display("FAIL char_E: n=%0d len=%0d bits=%b err=%b asc=%h want n=1 len=1 bits=00000 err=0 asc=%h",
                  clen_q.size(), clen_q[0], cbits_q[0], cerr_q[0], casc_q[0], exp_ascii(8'h45));
      else passes++;
      checks++;
      if (bus.busy !== 1'b0) $display("FAIL dot_back_idle: busy=%b want 0", bus.busy);
      else passes++;
   endtask

   task automatic test_dash_dot();
      clear_log();
      press(30);
      wait_cyc(10);
      press(10);
      wait_cyc(60);
      checks++;
      if (sym_q.size() !== 2 || sym_q[0] !== 1'b1 || sym_q[1] !== 1'b0)
         $display("FAIL symbols_N: count=%0d s0=%b s1=%b want count=2 s0=1 s1=0", sym_q.size(), sym_q[0], sym_q[1]);
      else passes++;
      checks++;
      if (clen_q.size() !== 1 || {clen_q[0], cbits_q[0], cerr_q[0], casc_q[0]} !== {3'd2, 5'b00001, 1'b0, exp_ascii(8'h4E)})
         $display("FAIL char_N: n=%0d len=%0d bits=%b err=%b asc=%h want n=1 len=2 bits=00001 err=0 asc=%h",
                  clen_q.size(), clen_q[0], cbits_q[0], cerr_q[0], casc_q[0], exp_ascii(8'h4E));
      else passes++;
   endtask

   task automatic test_glitch();
      clear_log();
      for (int i = 0; i < 5; i++) begin
         press(2);
         wait_cyc(2);
      end
      wait_cyc(20);
      checks++;
      if (sym_q.size() !== 0) $display("FAIL glitch_symbols: count=%0d want 0", sym_q.size());
      else passes++;
      checks++;
      if (busy_seen !== 1'b0) $display("FAIL glitch_busy: busy_seen=%b want 0", busy_seen);
      else passes++;
   endtask

   task automatic test_overflow();
      clear_log();
      for (int i = 0; i < 6; i++) begin
         press(10);
         wait_cyc(10);
      end
      wait_cyc(50);
      checks++;
      if (sym_q.size() !== 6) $display("FAIL overflow_symbols: count=%0d want 6", sym_q.size());
      else passes++;
      checks++;
      if (clen_q.size() !== 1 || {clen_q[0], cbits_q[0], cerr_q[0], casc_q[0]} !== {3'd5, 5'b00000, 1'b1, exp_ascii(8'h3F)})
         $display("FAIL overflow_char: n=%0d len=%0d bits=%b err=%b asc=%h want n=1 len=5 bits=00000 err=1 asc=%h",
                  clen_q.size(), clen_q[0], cbits_q[0], cerr_q[0], casc_q[0], exp_ascii(8'h3F));
      else passes++;
      // error must not leak into the next character
      clear_log();
      press(10);
      wait_cyc(60);
      checks++;
      if (clen_q.size() !== 1 || {clen_q[0], cbits_q[0], cerr_q[0], casc_q[0]} !== {3'd1, 5'b00000, 1'b0, exp_ascii(8'h45)})
         $display("FAIL overflow_cleared: n=%0d len=%0d bits=%b err=%b asc=%h want n=1 len=1 bits=00000 err=0 asc=%h",
                  clen_q.size(), clen_q[0], cbits_q[0], cerr_q[0], casc_q[0], exp_ascii(8'h45));
      else passes++;
   endtask

   task automatic test_reset_mid_press();
      bus.key = 1'b1;
      wait_cyc(15);
      checks++;
      if (bus.busy !== 1'b1) $display("FAIL midpress_busy: busy=%b want 1", bus.busy);
      else passes++;
      rst = 1'b1;
      wait_cyc(2);
      checks++;
      if ({bus.symbol_valid, bus.char_valid, bus.char_len, bus.char_bits, bus.char_error,
           bus.ascii, bus.busy} !== 19'd0)
         $display("FAIL midpress_reset_outputs: sv=%b cv=%b len=%0d bits=%b err=%b asc=%h busy=%b want all 0",
                  bus.symbol_valid, bus.char_valid, bus.char_len, bus.char_bits, bus.char_error,
                  bus.ascii, bus.busy);
      else passes++;
      rst = 1'b0;
      clear_log();
      wait_cyc(30);
      bus.key = 1'b0;
      wait_cyc(60);
      checks++;
      if (sym_q.size() !== 0 || clen_q.size() !== 0 || busy_seen !== 1'b0)
         $display("FAIL held_key_ignored: symbols=%0d chars=%0d busy_seen=%b want 0 0 0",
                  sym_q.size(), clen_q.size(), busy_seen);
      else passes++;
      clear_log();
      press(10);
      wait_cyc(60);
      checks++;
      if (sym_q.size() !== 1 || clen_q.size() !== 1 || {clen_q[0], cbits_q[0]} !== {3'd1, 5'b00000})
         $display("FAIL after_reset_press: symbols=%0d chars=%0d len=%0d bits=%b want 1 1 len=1 bits=00000",
                  sym_q.size(), clen_q.size(), clen_q[0], cbits_q[0]);
      else passes++;
   endtask

   task automatic test_boundaries();
      clear_log();
      press(20);
      wait_cyc(60);
      press(19);
      wait_cyc(60);
      checks++;
      if (sym_q.size() !== 2 || sym_q[0] !== 1'b1 || sym_q[1] !== 1'b0)
         $display("FAIL dash_threshold: count=%0d p20=%b p19=%b want count=2 p20=1 p19=0",
                  sym_q.size(), sym_q[0], sym_q[1]);
      else passes++;
      checks++;
      if (clen_q.size() !== 2 || {cbits_q[0], casc_q[0], cbits_q[1], casc_q[1]} !==
          {5'b00001, exp_ascii(8'h54), 5'b00000, exp_ascii(8'h45)})
         $display("FAIL chars_T_E: n=%0d bits0=%b asc0=%h bits1=%b asc1=%h want n=2 00001/%h 00000/%h",
                  clen_q.size(), cbits_q[0], casc_q[0], cbits_q[1], casc_q[1], exp_ascii(8'h54), exp_ascii(8'h45));
      else passes++;
      // gap of 39 keeps the character open
      clear_log();
      press(10);
      wait_cyc(39);
      press(10);
      wait_cyc(60);
      checks++;
      if (clen_q.size() !== 1 || {clen_q[0], cbits_q[0], casc_q[0]} !== {3'd2, 5'b00000, exp_ascii(8'h49)})
         $display("FAIL gap39_kept: n=%0d len=%0d bits=%b asc=%h want n=1 len=2 bits=00000 asc=%h",
                  clen_q.size(), clen_q[0], cbits_q[0], casc_q[0], exp_ascii(8'h49));
      else passes++;
      // gap of 40: timeout and new press coincide, both characters survive
      clear_log();
      press(10);
      wait_cyc(40);
      press(25);
      wait_cyc(60);
      checks++;
      if (clen_q.size() !== 2 || {clen_q[0], cbits_q[0], clen_q[1], cbits_q[1]} !== {3'd1, 5'b00000, 3'd1, 5'b00001})
         $display("FAIL gap40_simultaneous: n=%0d len0=%0d bits0=%b len1=%0d bits1=%b want n=2 1/00000 1/00001",
                  clen_q.size(), clen_q[0], cbits_q[0], clen_q[1], cbits_q[1]);
      else passes++;
   endtask

   task automatic test_clear_after_char();
      int waited;
      press(25);
      waited = 0;
      while (bus.char_valid !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if ({bus.char_valid, bus.char_len, bus.char_bits, bus.char_error, bus.ascii} !==
          {1'b1, 3'd1, 5'b00001, 1'b0, exp_ascii(8'h54)})
         $display("FAIL char_T_pulse: cv=%b len=%0d bits=%b err=%b asc=%h want cv=1 len=1 bits=00001 err=0 asc=%h",
                  bus.char_valid, bus.char_len, bus.char_bits, bus.char_error, bus.ascii, exp_ascii(8'h54));
      else passes++;
      wait_cyc(1);
      checks++;
      if ({bus.char_valid, bus.char_len, bus.char_bits, bus.char_error, bus.ascii} !== 18'd0)
         $display("FAIL char_fields_cleared: cv=%b len=%0d bits=%b err=%b asc=%h want all 0",
                  bus.char_valid, bus.char_len, bus.char_bits, bus.char_error, bus.ascii);
      else passes++;
      wait_cyc(5);
   endtask

   initial begin
      checks    = 0;
      passes    = 0;
      busy_seen = 1'b0;
      rst       = 1'b1;
      bus.key   = 1'b0;
      test_reset();
      test_single_dot();
      test_dash_dot();
      test_glitch();
      test_overflow();
      test_reset_mid_press();
      test_boundaries();
      test_clear_after_char();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
